exception_ctrl: RTL and testbench
=================================

Name: exception_ctrl

Overview:
- Parametrised exception/interrupt controller for the LEGv8 single-cycle core with exceptions.
- Sits beside the main decoder and takes that decoder's NotAnInstr/ERet outputs, so the decoder no longer drives the exception-status field.
- Adds multi-channel IRQs, pending latches, masking, priority, ELR/ESR capture, a handler state machine and a double-fault flag.

Parameters:
- NUM_IRQ, 4, number of external IRQ lines (1..8)
- ADDR_W, 64, PC/ELR width
- ESR_W, 4, exception status width (fixed encoding below; ≥4)

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- ExtIRQ  in  NUM_IRQ  external interrupt requests
- irq_mask  in  NUM_IRQ  1 = line masked
- instr_valid  in  1  current instruction is real (not a bubble/flush)
- NotAnInstr  in  1  decoder flags an invalid opcode
- ERet  in  1  decoder flags ERET
- pc  in  ADDR_W  PC of the current instruction
- exc_req  out  1  combinational: an exception is taken this cycle; core squashes write-back and memory write
- exc_take  out  1  registered one-cycle pulse; core redirects PC to the vector
- exc_ret  out  1  registered one-cycle pulse; core redirects PC to ELR
- ELR  out  ADDR_W  exception link register
- EStatus  out  ESR_W  captured cause
- irq_ack  out  NUM_IRQ  one-hot pulse, concurrent with exc_take, for the taken line
- in_handler  out  1  state == HANDLER
- double_fault  out  1  sticky; set on an invalid instruction while in HANDLER

Behaviour:
- Reset (asynchronous, active-low): state RUN; ELR = 0; EStatus = 0; pending = 0; all pulses, in_handler and double_fault = 0. Asserting reset mid-handler aborts the handler immediately.
- pending[i] latch:
  - Level mode: pending[i] = ExtIRQ[i] each cycle.
  - Set/clear rules in edge mode are under Optional Feature.
- Cause selection, combinational, only in RUN with instr_valid = 1:
  - Any line with pending & ~irq_mask: lowest index i wins; EStatus code is 1 followed by i[2:0] in the low bits (e.g. IRQ0 = 4'b1000, IRQ3 = 4'b1011).
  - Otherwise, NotAnInstr = 1 or ERet = 1 (ERET outside a handler is illegal): code 4'b0010.
  - IRQs beat the invalid-opcode cause.
  - No cause: exc_req = 0.
- States: RUN, TAKE, HANDLER.
- RUN: if exc_req = 1, then at the next edge:
  - ELR ← pc
  - EStatus ← code
  - state ← TAKE
  - exc_take = 1 and irq_ack[i] = 1 (IRQ case only) during TAKE
  - Latency: cause detected in cycle N; ELR/EStatus/exc_take valid in cycle N+1.
- TAKE: lasts exactly one cycle, then HANDLER. No cause is evaluated in TAKE.
- HANDLER:
  - All IRQs are held pending (no nesting).
  - instr_valid & ERet: exc_ret pulses in the next cycle; state ← RUN; ELR and EStatus are held.
  - instr_valid & NotAnInstr: double_fault ← 1 (sticky until reset); no state change.
- Simultaneous events:
  - ERet plus a pending IRQ in HANDLER: return first; the IRQ is evaluated in the first RUN cycle, giving back-to-back exc_ret then exc_take.
  - instr_valid = 0 suppresses every cause; IRQs wait.
- A masked line stays pending and is taken once it is unmasked.

Optional Feature:
- Macro: IRQ_EDGE_EN.
- Defined:
  - ExtIRQ is registered once; a rising edge sets pending[i].
  - irq_ack[i] clears pending[i].
  - Set and clear in the same cycle: set wins.
- Undefined: level mode; irq_ack is still driven, and the source must deassert the line itself.

Decomposition:
- Package exc_pkg:
  - state enum exc_state_t {RUN, TAKE, HANDLER}
  - ESR_NONE = 4'b0000, ESR_INVALID = 4'b0010, ESR_IRQ_BASE = 4'b1000
  - function irq_code(i)
- Sub-module irq_prio_enc (parameter NUM_IRQ): pending & ~mask → valid, index, one-hot.

Test Plan:
- Reset with ExtIRQ = 4'b1111 → all outputs 0; after release with irq_mask = 0 and instr_valid = 1, pc = 0x40 → exc_take at N+1, ELR = 0x40, EStatus = 4'b1000, irq_ack = 4'b0001.
- NotAnInstr with pc = 0x100, no IRQ → EStatus = 4'b0010, ELR = 0x100; then ERet in HANDLER → exc_ret one cycle later, in_handler = 0.
- ExtIRQ[2] and NotAnInstr together, irq_mask = 4'b0001 → IRQ2 wins, EStatus = 4'b1010; the masked IRQ0 is still pending and is taken after ERET once unmasked.
- IRQ1 raised while in HANDLER, then ERet → exc_ret then exc_take on consecutive cycles, EStatus = 4'b1001.
- NotAnInstr in HANDLER → double_fault = 1; it persists through ERET and clears only on reset asserted mid-handler, which also forces state to RUN.
- With IRQ_EDGE_EN: a 1-cycle ExtIRQ[3] pulse while instr_valid = 0 → pending is held; taken when instr_valid = 1 → EStatus = 4'b1011, pending cleared.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
// Shared types and cause encodings for the LEGv8 exception controller.
// Exception status codes are 4 bits; wider status registers zero-extend them.
package exc_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2
  } exc_state_t;

  localparam logic [3:0] ESR_NONE     = 4'b0000;
  localparam logic [3:0] ESR_INVALID  = 4'b0010;
  localparam logic [3:0] ESR_IRQ_BASE = 4'b1000;

  // IRQ cause code: MSB set, line index in the low three bits.
  function automatic logic [3:0] irq_code(input logic [2:0] idx);
    return ESR_IRQ_BASE | {1'b0, idx};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder over unmasked pending IRQ lines; lowest index wins.
// Purely combinational; idx is meaningful only when vld is high.
module irq_prio_enc #(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] pend,
  input  logic [NUM_IRQ-1:0] mask,
  output logic               vld,
  output logic [2:0]         idx,
  output logic [NUM_IRQ-1:0] onehot
);

  logic [NUM_IRQ-1:0] req;

  assign req = pend & ~mask;

  // Scan from the top so the lowest requesting index is the last to assign.
  always_comb begin
    vld    = 1'b0;
    idx    = 3'd0;
    onehot = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld       = 1'b1;
        idx       = 3'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception/IRQ controller: pending latches, masking, priority, ELR/ESR capture, handler FSM.
// Define IRQ_EDGE_EN for rising-edge IRQ latching cleared by irq_ack; default is level mode.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int ADDR_W  = 64,
  parameter int ESR_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] ExtIRQ,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               instr_valid,
  input  logic               NotAnInstr,
  input  logic               ERet,
  input  logic [ADDR_W-1:0]  pc,
  output logic               exc_req,
  output logic               exc_take,
  output logic               exc_ret,
  output logic [ADDR_W-1:0]  ELR,
  output logic [ESR_W-1:0]   EStatus,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_handler,
  output logic               double_fault
);

  exc_state_t         state, state_d;
  logic [NUM_IRQ-1:0] pending;
  logic               irq_vld;
  logic [2:0]         irq_idx;
  logic [NUM_IRQ-1:0] irq_onehot;
  logic [3:0]         cause_code;
  logic [NUM_IRQ-1:0] ack_d;
  logic               ret_d;
  logic               df_set;

`ifdef IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] ext_q;

  // A fresh rising edge beats the acknowledge clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_q   <= '0;
      pending <= '0;
    end else begin
      ext_q   <= ExtIRQ;
      pending <= (pending & ~irq_ack) | (ExtIRQ & ~ext_q);
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= ExtIRQ;
    end
  end
`endif

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .pend   (pending),
    .mask   (irq_mask),
    .vld    (irq_vld),
    .idx    (irq_idx),
    .onehot (irq_onehot)
  );

  // Causes are only considered in RUN; an ERET seen here is outside any handler.
  always_comb begin
    exc_req    = 1'b0;
    cause_code = ESR_NONE;
    ack_d      = '0;
    if (state == RUN && instr_valid) begin
      if (irq_vld) begin
        exc_req    = 1'b1;
        cause_code = irq_code(irq_idx);
        ack_d      = irq_onehot;
      end else if (NotAnInstr || ERet) begin
        exc_req    = 1'b1;
        cause_code = ESR_INVALID;
      end
    end
  end

  always_comb begin
    state_d = state;
    ret_d   = 1'b0;
    df_set  = 1'b0;
    case (state)
      RUN: begin
        if (exc_req) begin
          state_d = TAKE;
        end
      end
      TAKE: begin
        state_d = HANDLER;
      end
      HANDLER: begin
        if (instr_valid && ERet) begin
          state_d = RUN;
          ret_d   = 1'b1;
        end
        if (instr_valid && NotAnInstr) begin
          df_set = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      ELR          <= '0;
      EStatus      <= '0;
      exc_take     <= 1'b0;
      exc_ret      <= 1'b0;
      irq_ack      <= '0;
      double_fault <= 1'b0;
    end else begin
      state    <= state_d;
      exc_take <= exc_req;
      exc_ret  <= ret_d;
      irq_ack  <= ack_d;
      if (exc_req) begin
        ELR     <= pc;
        EStatus <= ESR_W'(cause_code);
      end
      if (df_set) begin
        double_fault <= 1'b1;
      end
    end
  end

  assign in_handler = (state == HANDLER);

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed-vector bench for exception_ctrl in the default (level IRQ) build.
module tb_exception_ctrl;
  import exc_pkg::*;

  localparam int NUM_IRQ = 4;
  localparam int ADDR_W  = 64;
  localparam int ESR_W   = 4;

  logic               clk;
  logic               reset;
  logic [NUM_IRQ-1:0] ExtIRQ;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               instr_valid;
  logic               NotAnInstr;
  logic               ERet;
  logic [ADDR_W-1:0]  pc;
  logic               exc_req;
  logic               exc_take;
  logic               exc_ret;
  logic [ADDR_W-1:0]  ELR;
  logic [ESR_W-1:0]   EStatus;
  logic [NUM_IRQ-1:0] irq_ack;
  logic               in_handler;
  logic               double_fault;

  int total = 0;
  int bad   = 0;

  exception_ctrl #(
    .NUM_IRQ (NUM_IRQ),
    .ADDR_W  (ADDR_W),
    .ESR_W   (ESR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ExtIRQ       (ExtIRQ),
    .irq_mask     (irq_mask),
    .instr_valid  (instr_valid),
    .NotAnInstr   (NotAnInstr),
    .ERet         (ERet),
    .pc           (pc),
    .exc_req      (exc_req),
    .exc_take     (exc_take),
    .exc_ret      (exc_ret),
    .ELR          (ELR),
    .EStatus      (EStatus),
    .irq_ack      (irq_ack),
    .in_handler   (in_handler),
    .double_fault (double_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    ExtIRQ      = 4'b1111;
    irq_mask    = 4'b0000;
    instr_valid = 1'b1;
    NotAnInstr  = 1'b0;
    ERet        = 1'b0;
    pc          = 64'h40;

    // Reset held with every IRQ asserted: everything stays quiet.
    tick();
    tick();
    chk("rst_req",    exc_req,      1'b0);
    chk("rst_take",   exc_take,     1'b0);
    chk("rst_ret",    exc_ret,      1'b0);
    chk("rst_elr",    ELR,          64'h0);
    chk("rst_esr",    EStatus,      4'b0000);
    chk("rst_ack",    irq_ack,      4'b0000);
    chk("rst_inh",    in_handler,   1'b0);
    chk("rst_df",     double_fault, 1'b0);

    // Release: IRQ0 wins, taken one cycle after detection.
    reset = 1'b1;
    tick();
    #1;
    chk("t1_req",     exc_req,      1'b1);
    tick();
    chk("t1_take",    exc_take,     1'b1);
    chk("t1_elr",     ELR,          64'h40);
    chk("t1_esr",     EStatus,      4'b1000);
    chk("t1_ack",     irq_ack,      4'b0001);
    chk("t1_inh_take", in_handler,  1'b0);
    ExtIRQ = 4'b0000;
    tick();
    chk("t1_inh",     in_handler,   1'b1);
    chk("t1_take_off", exc_take,    1'b0);
    chk("t1_ack_off", irq_ack,      4'b0000);
    ERet = 1'b1;
    tick();
    chk("t1_ret",     exc_ret,      1'b1);
    chk("t1_inh_ret", in_handler,   1'b0);
    chk("t1_elr_hold", ELR,         64'h40);
    chk("t1_esr_hold", EStatus,     4'b1000);

    // Invalid opcode with no IRQ, then a legal ERET from the handler.
    ERet       = 1'b0;
    NotAnInstr = 1'b1;
    pc         = 64'h100;
    #1;
    chk("t2_req",     exc_req,      1'b1);
    tick();
    chk("t2_take",    exc_take,     1'b1);
    chk("t2_ret_off", exc_ret,      1'b0);
    chk("t2_elr",     ELR,          64'h100);
    chk("t2_esr",     EStatus,      4'b0010);
    chk("t2_ack",     irq_ack,      4'b0000);
    NotAnInstr = 1'b0;
    tick();
    chk("t2_inh",     in_handler,   1'b1);
    ERet = 1'b1;
    tick();
    chk("t2_ret",     exc_ret,      1'b1);
    chk("t2_inh_ret", in_handler,   1'b0);
    chk("t2_df",      double_fault, 1'b0);

    // IRQ2 + IRQ0 + invalid opcode, IRQ0 masked: bubble first suppresses all.
    ERet        = 1'b0;
    ExtIRQ      = 4'b0101;
    irq_mask    = 4'b0001;
    NotAnInstr  = 1'b1;
    instr_valid = 1'b0;
    #1;
    chk("t3_bubble",  exc_req,      1'b0);
    tick();
    chk("t3_bubble2", exc_req,      1'b0);
    instr_valid = 1'b1;
    pc          = 64'h200;
    #1;
    chk("t3_req",     exc_req,      1'b1);
    tick();
    chk("t3_take",    exc_take,     1'b1);
    chk("t3_esr",     EStatus,      4'b1010);
    chk("t3_elr",     ELR,          64'h200);
    chk("t3_ack",     irq_ack,      4'b0100);
    ExtIRQ     = 4'b0001;
    NotAnInstr = 1'b0;
    tick();
    chk("t3_inh",     in_handler,   1'b1);
    irq_mask = 4'b0000;
    ERet     = 1'b1;
    #1;
    chk("t3_no_nest", exc_req,      1'b0);
    tick();
    chk("t3_ret",     exc_ret,      1'b1);
    ERet = 1'b0;
    pc   = 64'h300;
    #1;
    chk("t3_req0",    exc_req,      1'b1);
    tick();
    chk("t3_take0",   exc_take,     1'b1);
    chk("t3_ret_off", exc_ret,      1'b0);
    chk("t3_esr0",    EStatus,      4'b1000);
    chk("t3_ack0",    irq_ack,      4'b0001);
    chk("t3_elr0",    ELR,          64'h300);
    ExtIRQ = 4'b0000;
    tick();

    // IRQ1 raised inside the handler waits, then follows the return back-to-back.
    ExtIRQ = 4'b0010;
    tick();
    chk("t4_inh",     in_handler,   1'b1);
    chk("t4_no_take", exc_take,     1'b0);
    ERet = 1'b1;
    pc   = 64'h400;
    tick();
    chk("t4_ret",     exc_ret,      1'b1);
    ERet = 1'b0;
    pc   = 64'h404;
    tick();
    chk("t4_take",    exc_take,     1'b1);
    chk("t4_ret_off", exc_ret,      1'b0);
    chk("t4_esr",     EStatus,      4'b1001);
    chk("t4_elr",     ELR,          64'h404);
    chk("t4_ack",     irq_ack,      4'b0010);
    ExtIRQ = 4'b0000;
    tick();

    // Double fault is sticky across ERET and cleared only by reset.
    NotAnInstr = 1'b1;
    tick();
    chk("t5_df",      double_fault, 1'b1);
    chk("t5_inh",     in_handler,   1'b1);
    NotAnInstr = 1'b0;
    ERet       = 1'b1;
    tick();
    chk("t5_ret",     exc_ret,      1'b1);
    chk("t5_df_hold", double_fault, 1'b1);
    ERet       = 1'b0;
    NotAnInstr = 1'b1;
    pc         = 64'h500;
    tick();
    chk("t5_esr",     EStatus,      4'b0010);
    NotAnInstr = 1'b0;
    tick();
    chk("t5_inh2",    in_handler,   1'b1);
    reset = 1'b0;
    #1;
    chk("t5_rst_inh", in_handler,   1'b0);
    chk("t5_rst_df",  double_fault, 1'b0);
    chk("t5_rst_elr", ELR,          64'h0);
    chk("t5_rst_esr", EStatus,      4'b0000);
    tick();
    reset = 1'b1;
    tick();
    chk("t5_run",     in_handler,   1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
